dac_spi_receiver: RTL and testbench

//  Receiving end of the projector's serial DAC link (csn/sclk/mosi/latchn). It oversamples the four pins on
//  the system clock, deserialises 16-bit MCP4922-style command words and holds them per channel. On the

---
 rtl/dac_spi_receiver_pkg.sv | 24 ++
 rtl/dac_spi_receiver_pin_sync_edge.sv | 31 +++
 rtl/dac_spi_receiver.sv | 160 ++++++++++++++++
 tb/tb_dac_spi_receiver.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_spi_receiver_pkg.sv
// Shared constants for the DAC serial-link receiver.
// Covers word field positions, reset values and FSM state encodings.
package dac_spi_receiver_pkg;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned DATA_W     = 12;
    localparam int unsigned CNT_W      = 5;
    localparam int unsigned STAGE_W    = FRAME_BITS - 1;

    localparam int unsigned CH_BIT   = 15;
    localparam int unsigned BUF_BIT  = 14;
    localparam int unsigned GA_BIT   = 13;
    localparam int unsigned SHDN_BIT = 12;

    localparam logic [2:0]       CFG_RESET = 3'b011;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FRAME_BITS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        OVERRUN = 2'd2
    } rx_state_e;

endpackage

// File: rtl/dac_spi_receiver_pin_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with single-cycle rise/fall pulses.
// All flops reset high, which is the idle level of the link pins.
module pin_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/dac_spi_receiver.sv
// Loopback monitor of the serial DAC port: deserialises 16-bit command words into per-channel
// staging and publishes both channels as parallel X/Y codes on a latch falling edge.
module dac_spi_receiver
    import dac_spi_receiver_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              spi_csn,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    input  logic              spi_latchn,
    output logic [DATA_W-1:0] chan_a_out,
    output logic [DATA_W-1:0] chan_b_out,
    output logic [2:0]        cfg_a,
    output logic [2:0]        cfg_b,
    output logic              pend_a,
    output logic              pend_b,
    output logic              frame_stb,
    output logic              frame_err,
    output logic              update_stb
);

    logic csn_level, csn_rise, csn_fall;
    logic sclk_level, sclk_rise, sclk_fall;
    logic mosi_level, unused_mosi_rise, unused_mosi_fall;
    logic latch_level, latch_rise, latch_fall;
    logic unused_levels;

    pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_csn (
        .clk   (clk),
        .reset (reset),
        .pin   (spi_csn),
        .level (csn_level),
        .rise  (csn_rise),
        .fall  (csn_fall)
    );

    pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk   (clk),
        .reset (reset),
        .pin   (spi_sclk),
        .level (sclk_level),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk   (clk),
        .reset (reset),
        .pin   (spi_mosi),
        .level (mosi_level),
        .rise  (unused_mosi_rise),
        .fall  (unused_mosi_fall)
    );

    pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_latch (
        .clk   (clk),
        .reset (reset),
        .pin   (spi_latchn),
        .level (latch_level),
        .rise  (latch_rise),
        .fall  (latch_fall)
    );

    assign unused_levels = ^{csn_level, sclk_level, sclk_fall, latch_level, latch_rise};

    rx_state_e              state_q;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic [FRAME_BITS-1:0]  shift_q;
    logic [STAGE_W-1:0]     stage_a_q, stage_a_d;
    logic [STAGE_W-1:0]     stage_b_q, stage_b_d;
    logic                   commit, commit_a, commit_b;

    assign commit   = (state_q == SHIFT) && csn_rise && (bit_cnt_q == FULL_CNT);
    assign commit_a = commit && !shift_q[CH_BIT];
    assign commit_b = commit && shift_q[CH_BIT];

    // Next staging is used for both staging and the outputs so a same-cycle latch writes through.
    always_comb begin
        stage_a_d = stage_a_q;
        stage_b_d = stage_b_q;
        if (commit_a) stage_a_d = shift_q[STAGE_W-1:0];
        if (commit_b) stage_b_d = shift_q[STAGE_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            frame_stb <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_stb <= 1'b0;
            frame_err <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (csn_fall) begin
                        state_q   <= SHIFT;
                        bit_cnt_q <= '0;
                        shift_q   <= '0;
                    end
                end
                SHIFT: begin
                    if (csn_rise) begin
                        frame_stb <= (bit_cnt_q == FULL_CNT);
                        frame_err <= (bit_cnt_q != FULL_CNT);
                        state_q   <= IDLE;
                    end else if (sclk_rise) begin
                        if (bit_cnt_q == FULL_CNT) begin
                            state_q <= OVERRUN;
                        end else begin
                            shift_q   <= {shift_q[FRAME_BITS-2:0], mosi_level};
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                OVERRUN: begin
                    if (csn_rise) begin
                        frame_err <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_a_q  <= '0;
            stage_b_q  <= '0;
            chan_a_out <= '0;
            chan_b_out <= '0;
            cfg_a      <= CFG_RESET;
            cfg_b      <= CFG_RESET;
            pend_a     <= 1'b0;
            pend_b     <= 1'b0;
            update_stb <= 1'b0;
        end else begin
            stage_a_q  <= stage_a_d;
            stage_b_q  <= stage_b_d;
            update_stb <= latch_fall;
            if (latch_fall) begin
                chan_a_out <= stage_a_d[DATA_W-1:0];
                chan_b_out <= stage_b_d[DATA_W-1:0];
                cfg_a      <= stage_a_d[BUF_BIT:SHDN_BIT];
                cfg_b      <= stage_b_d[BUF_BIT:SHDN_BIT];
                pend_a     <= 1'b0;
                pend_b     <= 1'b0;
            end else begin
                if (commit_a) pend_a <= 1'b1;
                if (commit_b) pend_b <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dac_spi_receiver.sv
// Self-checking bench for dac_spi_receiver: directed vector table, corner sequences and
// randomised frames compared with a word-level model of staging/publish behaviour.
module tb_dac_spi_receiver;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        spi_csn = 1'b1;
    logic        spi_sclk = 1'b0;
    logic        spi_mosi = 1'b1;
    logic        spi_latchn = 1'b1;
    logic [11:0] chan_a_out, chan_b_out;
    logic [2:0]  cfg_a, cfg_b;
    logic        pend_a, pend_b, frame_stb, frame_err, update_stb;

    dac_spi_receiver #(.SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .spi_csn    (spi_csn),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi),
        .spi_latchn (spi_latchn),
        .chan_a_out (chan_a_out),
        .chan_b_out (chan_b_out),
        .cfg_a      (cfg_a),
        .cfg_b      (cfg_b),
        .pend_a     (pend_a),
        .pend_b     (pend_b),
        .frame_stb  (frame_stb),
        .frame_err  (frame_err),
        .update_stb (update_stb)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Strobe pulse counters, sampled mid-cycle.
    int mon_stb = 0, mon_err = 0, mon_upd = 0, mon_both = 0;
    always @(negedge clk) begin
        if (frame_stb)               mon_stb  <= mon_stb + 1;
        if (frame_err)               mon_err  <= mon_err + 1;
        if (update_stb)              mon_upd  <= mon_upd + 1;
        if (frame_stb && update_stb) mon_both <= mon_both + 1;
    end

    // Word-level reference: index 0 = channel A, 1 = channel B; entries are word bits [14:0].
    logic [14:0] m_stage [2];
    logic [14:0] m_pub   [2];
    bit          m_pend  [2];
    int          e_stb = 0, e_err = 0, e_upd = 0, e_both = 0;
    bit          skew_en = 1'b0;

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            m_stage[c] = 15'h0;
            m_pub[c]   = {3'b011, 12'h000};
            m_pend[c]  = 1'b0;
        end
    endfunction

    function automatic void model_frame(input logic [15:0] word, input int nbits);
        if (nbits == 16) begin
            m_stage[int'(word[15])] = word[14:0];
            m_pend[int'(word[15])]  = 1'b1;
            e_stb++;
        end else begin
            e_err++;
        end
    endfunction

    function automatic void model_latch();
        for (int c = 0; c < 2; c++) begin
            m_pub[c]  = m_stage[c];
            m_pend[c] = 1'b0;
        end
        e_upd++;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " chan_a"}, int'(chan_a_out), int'(m_pub[0][11:0]));
        check({tag, " chan_b"}, int'(chan_b_out), int'(m_pub[1][11:0]));
        check({tag, " cfg_a"},  int'(cfg_a),      int'(m_pub[0][14:12]));
        check({tag, " cfg_b"},  int'(cfg_b),      int'(m_pub[1][14:12]));
        check({tag, " pend_a"}, int'(pend_a),     int'(m_pend[0]));
        check({tag, " pend_b"}, int'(pend_b),     int'(m_pend[1]));
        check({tag, " n_frame_stb"},  mon_stb,  e_stb);
        check({tag, " n_frame_err"},  mon_err,  e_err);
        check({tag, " n_update_stb"}, mon_upd,  e_upd);
        check({tag, " n_stb_and_upd"}, mon_both, e_both);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic skew();
        if (skew_en) #($urandom_range(0, 3));
    endtask

    task automatic latch_pulse(input int settle);
        tick(); skew(); spi_latchn = 1'b0;
        tick(); tick(); skew(); spi_latchn = 1'b1;
        repeat (settle) tick();
    endtask

    // sclk runs at clk/4; mosi changes mid-low, one clk ahead of the rising edge.
    task automatic send_frame(input logic [15:0] word, input int nbits,
                              input bit latch_mid, input bit coincide);
        logic b;
        tick(); skew(); spi_csn = 1'b0;
        tick(); tick();
        for (int i = 0; i < nbits; i++) begin
            if (latch_mid && i == nbits / 2) latch_pulse(2);
            if (i < 16) b = word[15 - i];
            else        b = 1'($urandom);
            tick(); skew(); spi_mosi = b;
            tick(); skew(); spi_sclk = 1'b1;
            tick(); tick(); skew(); spi_sclk = 1'b0;
        end
        if (latch_mid && nbits == 0) latch_pulse(2);
        tick(); tick();
        if (coincide) begin
            tick();
            spi_csn    = 1'b1;
            spi_latchn = 1'b0;
            tick(); tick();
            spi_latchn = 1'b1;
        end else begin
            tick(); skew(); spi_csn = 1'b1;
        end
        repeat (6) tick();
    endtask

    typedef struct {
        logic [15:0] word;
        int          nbits;  // -1: no frame
        bit          latch;  // latch after the frame
        logic [11:0] a;
        logic [11:0] b;
        logic [2:0]  ca;
        logic [2:0]  cb;
        bit          pa;
        bit          pb;
    } vec_t;

    vec_t vecs [9];

    initial begin
        vecs[0] = '{16'h3ABC, 16, 1'b0, 12'h000, 12'h000, 3'b011, 3'b011, 1'b1, 1'b0};
        vecs[1] = '{16'h0000, -1, 1'b1, 12'hABC, 12'h000, 3'b011, 3'b000, 1'b0, 1'b0};
        vecs[2] = '{16'h3123, 16, 1'b0, 12'hABC, 12'h000, 3'b011, 3'b000, 1'b1, 1'b0};
        vecs[3] = '{16'hB456, 16, 1'b0, 12'hABC, 12'h000, 3'b011, 3'b000, 1'b1, 1'b1};
        vecs[4] = '{16'h0000, -1, 1'b1, 12'h123, 12'h456, 3'b011, 3'b011, 1'b0, 1'b0};
        vecs[5] = '{16'hC999, 15, 1'b0, 12'h123, 12'h456, 3'b011, 3'b011, 1'b0, 1'b0};
        vecs[6] = '{16'hC999, 17, 1'b0, 12'h123, 12'h456, 3'b011, 3'b011, 1'b0, 1'b0};
        vecs[7] = '{16'h0000, -1, 1'b1, 12'h123, 12'h456, 3'b011, 3'b011, 1'b0, 1'b0};
        vecs[8] = '{16'h4FFF, 16, 1'b1, 12'hFFF, 12'h456, 3'b100, 3'b011, 1'b0, 1'b0};

        model_reset();
        repeat (3) tick();
        check_model("reset");
        reset = 1'b0;
        repeat (4) tick();

        // Publish something non-zero, then abort a frame with reset.
        send_frame(16'h0F0F, 16, 1'b0, 1'b0);
        model_frame(16'h0F0F, 16);
        latch_pulse(6);
        model_latch();
        check_model("pre_reset");

        tick(); spi_csn = 1'b0;
        tick(); tick();
        for (int i = 0; i < 6; i++) begin
            tick(); spi_mosi = 1'b1;
            tick(); spi_sclk = 1'b1;
            tick(); tick(); spi_sclk = 1'b0;
        end
        tick(); spi_sclk = 1'b1;
        tick();
        reset = 1'b1;
        model_reset();
        #1;
        check_model("in_reset");
        spi_csn  = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b1;
        tick(); tick();
        reset = 1'b0;
        repeat (6) tick();
        check_model("after_reset");

        for (int v = 0; v < 9; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            if (vecs[v].nbits >= 0) begin
                send_frame(vecs[v].word, vecs[v].nbits, 1'b0, 1'b0);
                model_frame(vecs[v].word, vecs[v].nbits);
            end
            if (vecs[v].latch) begin
                latch_pulse(6);
                model_latch();
            end
            check({tag, " chan_a"}, int'(chan_a_out), int'(vecs[v].a));
            check({tag, " chan_b"}, int'(chan_b_out), int'(vecs[v].b));
            check({tag, " cfg_a"},  int'(cfg_a),      int'(vecs[v].ca));
            check({tag, " cfg_b"},  int'(cfg_b),      int'(vecs[v].cb));
            check({tag, " pend_a"}, int'(pend_a),     int'(vecs[v].pa));
            check({tag, " pend_b"}, int'(pend_b),     int'(vecs[v].pb));
            check_model(tag);
        end

        // Commit and latch detected in the same cycle: written through, pend ends clear.
        send_frame(16'hB7FF, 16, 1'b0, 1'b1);
        model_frame(16'hB7FF, 16);
        model_latch();
        e_both++;
        check("coincide chan_b", int'(chan_b_out), 32'h7FF);
        check("coincide pend_b", int'(pend_b), 0);
        check_model("coincide");

        // Latch while a frame is half-shifted publishes the old staging.
        skew_en = 1'b1;
        send_frame(16'h8222, 16, 1'b0, 1'b0);
        model_frame(16'h8222, 16);
        send_frame(16'h8333, 16, 1'b1, 1'b0);
        model_latch();
        model_frame(16'h8333, 16);
        check("midlatch chan_b", int'(chan_b_out), 32'h222);
        check("midlatch pend_b", int'(pend_b), 1);
        check_model("midlatch");

        for (int r = 0; r < 40; r++) begin
            logic [15:0] w;
            int          sel, nb;
            bit          lm, la;
            w   = 16'($urandom);
            sel = int'($urandom_range(0, 9));
            if (sel < 6)       nb = 16;
            else if (sel == 6) nb = 15;
            else if (sel == 7) nb = 17;
            else if (sel == 8) nb = int'($urandom_range(0, 14));
            else               nb = int'($urandom_range(18, 20));
            lm = ($urandom_range(0, 3) == 0);
            la = ($urandom_range(0, 2) == 0);
            send_frame(w, nb, lm, 1'b0);
            if (lm) model_latch();
            model_frame(w, nb);
            if (la) begin
                latch_pulse(6);
                model_latch();
            end
            check_model($sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
